// File: rtl/sram_controller_if.sv
// ---------------------------------------------------------------------------
// sram_controller_if
//   Bundles the two buses around the SRAM controller:
//     - pipeline side: rd_en, wr_en, address, write_data -> read_data, ready
//     - SRAM side:     sram_addr, sram_dq_out, sram_dq_oe, sram_we_n <- sram_dq_in
//   Modports:
//     slave  : the controller (consumes requests, drives the SRAM pins)
//     master : the surroundings (pipeline driving requests, SRAM returning data)
// ---------------------------------------------------------------------------
interface sram_controller_if #(
  parameter int unsigned SRAM_ADDR_W = 18
);
  logic                   rd_en;
  logic                   wr_en;
  logic [31:0]            address;
  logic [31:0]            write_data;
  logic [31:0]            read_data;
  logic                   ready;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [15:0]            sram_dq_out;
  logic                   sram_dq_oe;
  logic [15:0]            sram_dq_in;
  logic                   sram_we_n;

  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//   Data-memory back end for the MEM stage. One 32-bit load/store request is
//   split into two 16-bit SRAM accesses (low halfword, then high halfword),
//   followed by WAIT_CYCLES idle settle cycles and a one-cycle DONE in which
//   ready is raised so the pipeline advances.
//
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous, active-high reset
//     bus  - sram_controller_if.slave:
//              rd_en/wr_en/address/write_data in, read_data/ready out,
//              sram_addr/sram_dq_out/sram_dq_oe/sram_we_n out, sram_dq_in in
//
//   Address mapping: BASE_ADDR is SRAM word 0; the word index is
//   (address-BASE_ADDR)>>2 truncated to SRAM_ADDR_W-1 bits (wraps), and the
//   halfword address is {idx, half}. address[1:0] is ignored.
// ---------------------------------------------------------------------------
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  sram_controller_if.slave bus
);

  localparam int unsigned IDX_W = SRAM_ADDR_W - 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx_q;
  logic               is_write_q;
  logic [31:0]        wdata_q;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        read_data_q;

  logic               req;
  logic [IDX_W-1:0]   idx_next;

  assign req = bus.rd_en | bus.wr_en;

  // Explicit cast truncates the word index; upper bits wrap around.
  assign idx_next = IDX_W'((bus.address - 32'(BASE_ADDR)) >> 2);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx_q       <= '0;
      is_write_q  <= 1'b0;
      wdata_q     <= '0;
      cnt         <= '0;
      read_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            idx_q      <= idx_next;
            // A simultaneous read and write is treated as a read.
            is_write_q <= bus.wr_en & ~bus.rd_en;
            wdata_q    <= bus.write_data;
            state      <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (!is_write_q) read_data_q[15:0] <= bus.sram_dq_in;
          state <= ST_HIGH;
        end
        ST_HIGH: begin
          if (!is_write_q) read_data_q[31:16] <= bus.sram_dq_in;
          cnt   <= '0;
          state <= (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          if (32'(cnt) == WAIT_CYCLES - 1) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // The request is still asserted here but is deliberately ignored;
          // the pipeline advances on this edge.
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    bus.sram_addr   = '0;
    bus.sram_dq_out = '0;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_we_n   = 1'b1;
    case (state)
      ST_LOW: begin
        bus.sram_addr = {idx_q, 1'b0};
        if (is_write_q) begin
          bus.sram_dq_out = wdata_q[15:0];
          bus.sram_dq_oe  = 1'b1;
          bus.sram_we_n   = 1'b0;
        end
      end
      ST_HIGH: begin
        bus.sram_addr = {idx_q, 1'b1};
        if (is_write_q) begin
          bus.sram_dq_out = wdata_q[31:16];
          bus.sram_dq_oe  = 1'b1;
          bus.sram_we_n   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // ready drops in the same cycle a request appears in IDLE, so the stage
  // freezes immediately, and rises only in DONE.
  assign bus.ready     = ((state == ST_IDLE) && !req) || (state == ST_DONE);
  assign bus.read_data = read_data_q;

endmodule
